uart_fifo_wb: RTL

Wishbone-attached UART with parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt. It is the buffered, interrupt-capable successor to our single-byte Wishbone UART and sits on the SoC peripheral bus, with `serial_in`/`serial_out` going to the pads. Frame format is fixed at 8N1.

---
 rtl/uart_fifo_wb.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_wb.sv
// uart_fifo_wb: Wishbone UART, 8N1, with TX/RX FIFOs, programmable divisor, sticky errors and level irq.
// uart_fifo is the shared synchronous FIFO; full/empty are told apart by an extra pointer bit.
module uart_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    logic [7:0]  mem_q [2**AW];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic        push_ok, pop_ok;

    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout  = mem_q[rp_q[AW-1:0]];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wp_d = wp_q + (AW+1)'(push_ok);
        rp_d = rp_q + (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end

    always_ff @(posedge clk)
        if (push_ok) mem_q[wp_q[AW-1:0]] <= din;
endmodule

module uart_fifo_wb #(
    parameter int DIV_RESET = 434,
    parameter int FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        serial_in,
    output logic        serial_out,
    input  logic [29:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

    logic        ack_q, ack_d, irq_q, irq_d;
    logic [31:0] data_o_q, data_o_d, rdata;
    logic [15:0] div_q, div_d;
    logic [2:0]  ien_q, ien_d;
    logic        rx_ovr_q, rx_ovr_d, fe_q, fe_d, tx_ovf_q, tx_ovf_d;
    logic        acc, wr_data, rd_data, wr_stat, wr_div, wr_ien;
    logic        tx_empty, tx_full, tx_pop, tx_tick, tx_idle_st;
    logic        rx_empty, rx_full, rx_pop, rx_push, rx_tick, rx_end;
    logic [7:0]  tx_dout, rx_dout, status;
    logic        unused_bits;

    st_t         tx_st_q, rx_st_q;
    logic [15:0] tx_cnt_q, rx_cnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [7:0]  tx_sh_q, rx_sh_q;
    logic        tx_out_q, rx_s1_q, rx_s2_q, rx_prev_q;

    assign unused_bits = ^{addr_i[29:2], data_i[31:16]};

    // A held request is accepted only when no ack is pending, giving one ack every other cycle
    assign acc     = stb_i && cyc_i && !ack_q;
    assign wr_data = acc && we_i && addr_i[1:0] == 2'd0;
    assign rd_data = acc && !we_i && addr_i[1:0] == 2'd0;
    assign wr_stat = acc && we_i && addr_i[1:0] == 2'd1;
    assign wr_div  = acc && we_i && addr_i[1:0] == 2'd2;
    assign wr_ien  = acc && we_i && addr_i[1:0] == 2'd3;

    assign tx_tick    = tx_cnt_q == 16'd0;
    assign tx_idle_st = tx_empty && tx_st_q == IDLE;
    assign tx_pop     = !tx_empty && (tx_st_q == IDLE || (tx_st_q == STOP && tx_tick));
    assign rx_tick    = rx_cnt_q == 16'd0;
    assign rx_end     = rx_st_q == STOP && rx_tick;
    assign rx_pop     = rd_data && !rx_empty;
    assign rx_push    = rx_end && rx_s2_q && (!rx_full || rx_pop);

    assign status = {tx_ovf_q, fe_q, rx_ovr_q, tx_st_q != IDLE, tx_full, tx_idle_st, rx_full, !rx_empty};
    assign rdata  = addr_i[1:0] == 2'd0 ? (rx_empty ? 32'd0 : {23'd0, 1'b1, rx_dout}) :
                    addr_i[1:0] == 2'd1 ? {24'd0, status} :
                    addr_i[1:0] == 2'd2 ? {16'd0, div_q} : {29'd0, ien_q};

    uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_data), .pop(tx_pop), .din(data_i[7:0]),
        .dout(tx_dout), .empty(tx_empty), .full(tx_full)
    );

    uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
        .dout(rx_dout), .empty(rx_empty), .full(rx_full)
    );

    always_comb begin
        ack_d    = acc;
        data_o_d = (acc && !we_i) ? rdata : 32'd0;
        div_d    = wr_div ? (data_i[15:0] < 16'd4 ? 16'd4 : data_i[15:0]) : div_q;
        ien_d    = wr_ien ? data_i[2:0] : ien_q;
        rx_ovr_d = (rx_ovr_q && !(wr_stat && data_i[5])) || (rx_end && rx_s2_q && rx_full && !rx_pop);
        fe_d     = (fe_q && !(wr_stat && data_i[6])) || (rx_end && !rx_s2_q);
        tx_ovf_d = (tx_ovf_q && !(wr_stat && data_i[7])) || (wr_data && tx_full && !tx_pop);
        irq_d    = |(ien_q & {rx_ovr_q || fe_q || tx_ovf_q, tx_idle_st, !rx_empty});
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ack_q    <= 1'b0;
            data_o_q <= 32'd0;
            div_q    <= 16'(DIV_RESET);
            ien_q    <= 3'd0;
            rx_ovr_q <= 1'b0;
            fe_q     <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            data_o_q <= data_o_d;
            div_q    <= div_d;
            ien_q    <= ien_d;
            rx_ovr_q <= rx_ovr_d;
            fe_q     <= fe_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= irq_d;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_st_q  <= IDLE;
            tx_cnt_q <= 16'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'd0;
            tx_out_q <= 1'b1;
        end else if (tx_st_q == IDLE) begin
            if (!tx_empty) begin
                tx_st_q  <= START;
                tx_out_q <= 1'b0;
                tx_sh_q  <= tx_dout;
                tx_cnt_q <= div_q - 16'd1;
            end
        end else if (!tx_tick) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
        end else begin
            tx_cnt_q <= div_q - 16'd1;
            case (tx_st_q)
                START: begin
                    tx_st_q  <= DATA;
                    tx_bit_q <= 3'd0;
                    tx_out_q <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                end
                DATA: if (tx_bit_q == 3'd7) begin
                    tx_st_q  <= STOP;
                    tx_out_q <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 3'd1;
                    tx_out_q <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                end
                STOP: if (!tx_empty) begin
                    tx_st_q  <= START;
                    tx_out_q <= 1'b0;
                    tx_sh_q  <= tx_dout;
                end else begin
                    tx_st_q  <= IDLE;
                end
                default: tx_st_q <= IDLE;
            endcase
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= IDLE;
            rx_cnt_q  <= 16'd0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
        end else begin
            rx_s1_q   <= serial_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_st_q == IDLE) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= START;
                    rx_cnt_q <= {1'b0, div_q[15:1]} - 16'd1;
                end
            end else if (!rx_tick) begin
                rx_cnt_q <= rx_cnt_q - 16'd1;
            end else begin
                rx_cnt_q <= div_q - 16'd1;
                case (rx_st_q)
                    START: begin
                        rx_st_q  <= rx_s2_q ? IDLE : DATA;
                        rx_bit_q <= 3'd0;
                    end
                    DATA: begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_st_q <= STOP;
                    end
                    default: rx_st_q <= IDLE;
                endcase
            end
        end

    assign serial_out = tx_out_q;
    assign ack_o      = ack_q;
    assign data_o     = data_o_q;
    assign irq_o      = irq_q;
endmodule
